// File: rtl/xornor_pkg.sv
// Shared types and defaults for the XorNor arbiter.
// FSM state encoding, default sizing constants and the Res_Id width helper.
package xornor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CAP  = 2'd2
    } state_e;

    localparam int NREQ_DEF   = 4;
    localparam int SETTLE_DEF = 2;

    // Width of a requester index; never less than one bit.
    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/xornor_rr_pick.sv
// Combinational round-robin picker.
// Searches Req starting one past the last served requester and returns the
// first set bit as the winner; any_o flags that some request is pending.
module xornor_rr_pick
    import xornor_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IDW = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic [IDW-1:0]  win_o,
    output logic            any_o
);

    int             pos;
    logic [IDW-1:0] idx;

    // Rotate the search origin; wrap needs at most one subtraction since
    // last_i + 1 + k never reaches 2*NREQ.
    always_comb begin
        win_o = '0;
        any_o = 1'b0;
        pos   = 0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(last_i) + 1 + k;
            if (pos >= NREQ) pos = pos - NREQ;
            idx = pos[IDW-1:0];
            if (!any_o && req_i[idx]) begin
                win_o = idx;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xornor_arbiter.sv
// Arbiter sharing one external XorNor datapath between NREQ requesters.
// Each operation: issue (operands registered onto Dp_*), SETTLE wait cycles,
// capture of Dp_X/Dp_Y, then a one-cycle Done pulse.
// Optional self-check of the datapath results: define XORNOR_ARB_CHECK_EN.
module xornor_arbiter
    import xornor_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int SETTLE = SETTLE_DEF,
    localparam int IDW   = id_w(NREQ)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] in_a_i,
    input  logic [NREQ-1:0] in_b_i,
    input  logic [NREQ-1:0] in_c_i,
    output logic            dp_a_o,
    output logic            dp_b_o,
    output logic            dp_c_o,
    input  logic            dp_x_i,
    input  logic            dp_y_i,
    output logic [NREQ-1:0] grant_o,
    output logic            done_o,
    output logic            res_x_o,
    output logic            res_y_o,
    output logic [IDW-1:0]  res_id_o,
    output logic            err_o
);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            dp_a_q, dp_a_d, dp_b_q, dp_b_d, dp_c_q, dp_c_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            done_q, done_d;
    logic            res_x_q, res_x_d, res_y_q, res_y_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic [IDW-1:0]  win_q, win_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  win;
    logic            any;

    xornor_rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i  (req_i),
        .last_i (last_q),
        .win_o  (win),
        .any_o  (any)
    );

    // Next-state logic for the issue / wait / capture sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dp_a_d   = dp_a_q;
        dp_b_d   = dp_b_q;
        dp_c_d   = dp_c_q;
        grant_d  = grant_q;
        done_d   = 1'b0;
        res_x_d  = res_x_q;
        res_y_d  = res_y_q;
        res_id_d = res_id_q;
        win_d    = win_q;
        last_d   = last_q;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    dp_a_d       = in_a_i[win];
                    dp_b_d       = in_b_i[win];
                    dp_c_d       = in_c_i[win];
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    win_d        = win;
                    cnt_d        = '0;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(SETTLE - 1)) state_d = ST_CAP;
            end
            ST_CAP: begin
                res_x_d  = dp_x_i;
                res_y_d  = dp_y_i;
                res_id_d = win_q;
                last_d   = win_q;
                done_d   = 1'b1;
                grant_d  = '0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any operation in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dp_a_q   <= 1'b0;
            dp_b_q   <= 1'b0;
            dp_c_q   <= 1'b0;
            grant_q  <= '0;
            done_q   <= 1'b0;
            res_x_q  <= 1'b0;
            res_y_q  <= 1'b0;
            res_id_q <= '0;
            win_q    <= '0;
            last_q   <= IDW'(NREQ - 1);
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dp_a_q   <= dp_a_d;
            dp_b_q   <= dp_b_d;
            dp_c_q   <= dp_c_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            res_x_q  <= res_x_d;
            res_y_q  <= res_y_d;
            res_id_q <= res_id_d;
            win_q    <= win_d;
            last_q   <= last_d;
        end
    end

`ifdef XORNOR_ARB_CHECK_EN
    logic err_q;
    logic mismatch;

    assign mismatch = (dp_x_i != (dp_a_q ^ dp_b_q)) ||
                      (dp_y_i != ~((dp_a_q ^ dp_b_q) | dp_c_q));

    // Sticky error: set on a bad datapath result at capture, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                          err_q <= 1'b0;
        else if (state_q == ST_CAP && mismatch) err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign dp_a_o   = dp_a_q;
    assign dp_b_o   = dp_b_q;
    assign dp_c_o   = dp_c_q;
    assign grant_o  = grant_q;
    assign done_o   = done_q;
    assign res_x_o  = res_x_q;
    assign res_y_o  = res_y_q;
    assign res_id_o = res_id_q;

endmodule

// File: tb/tb_xornor_arbiter.sv
// Directed bench for xornor_arbiter (NREQ=4, SETTLE=2) with an attached
// XorNor model and a result scoreboard.
module tb_xornor_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, a, b, c;
    logic       dp_a, dp_b, dp_c, dp_x, dp_y;
    logic [3:0] grant;
    logic       done, res_x, res_y, err;
    logic [1:0] res_id;
    bit         force_x0 = 1'b0;

    typedef struct { int id; bit x; bit y; } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc;
    bit exp_err;

    always #5 clk = ~clk;

    // External XorNor datapath, with a fault injection on X.
    assign dp_x = force_x0 ? 1'b0 : (dp_a ^ dp_b);
    assign dp_y = ~((dp_a ^ dp_b) | dp_c);

    xornor_arbiter #(.NREQ(4), .SETTLE(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req),
        .in_a_i(a), .in_b_i(b), .in_c_i(c),
        .dp_a_o(dp_a), .dp_b_o(dp_b), .dp_c_o(dp_c),
        .dp_x_i(dp_x), .dp_y_i(dp_y),
        .grant_o(grant), .done_o(done),
        .res_x_o(res_x), .res_y_o(res_y), .res_id_o(res_id), .err_o(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    // Expected result for requester i from the operands as driven now.
    task automatic push(input int i);
        exp_t e;
        e.id = i;
        e.x  = force_x0 ? 1'b0 : (a[i] ^ b[i]);
        e.y  = ~((a[i] ^ b[i]) | c[i]);
        sb.push_back(e);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_dp"},    32'({dp_a, dp_b, dp_c}), 0);
        chk({tag, "_res"},   32'({res_x, res_y, res_id}), 0);
        chk({tag, "_err"},   32'(err), 0);
    endtask

    // Wait (bounded) for Done, compare against the scoreboard head.
    task automatic wait_done(input string tag, input int budget, input bit drop, output int n);
        exp_t e;
        n = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (done) begin
                n = k;
                break;
            end
        end
        if (n == 0) begin
            chk({tag, "_timeout"}, 0, 1);
        end else if (sb.size() == 0) begin
            chk({tag, "_unexpected_done"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_id"}, 32'(res_id), 32'(e.id));
            chk({tag, "_x"},  32'(res_x), 32'(e.x));
            chk({tag, "_y"},  32'(res_y), 32'(e.y));
        end
        if (drop) req = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
`ifdef XORNOR_ARB_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst_n = 1'b0; req = '0; a = '0; b = '0; c = '0;
        #2;
        all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester 0: A=1,B=0,C=0 -> X=1,Y=0, Done 3 edges after issue.
        @(negedge clk);
        req = 4'b0001; a = 4'b0001; b = '0; c = '0;
        push(0);
        @(negedge clk);
        chk("t1_grant0", 32'(grant), 4'b0001);
        chk("t1_dpa", 32'(dp_a), 1);
        @(negedge clk);
        chk("t1_grant1", 32'(grant), 4'b0001);
        @(negedge clk);
        chk("t1_grant2", 32'(grant), 4'b0001);
        chk("t1_nodone", 32'(done), 0);
        wait_done("t1", 1, 1'b1, cyc);
        chk("t1_grant_off", 32'(grant), 0);
        @(negedge clk);
        chk("t1_pulse", 32'(done), 0);
        chk("t1_hold_x", 32'(res_x), 1);

        // All requesting: round robin 0,1,2,3,0, four cycles apart.
        do_reset();
        a = 4'b1010; b = 4'b0110; c = 4'b0001;
        req = 4'b1111;
        push(0); push(1); push(2); push(3); push(0);
        for (int i = 0; i < 5; i++) begin
            wait_done($sformatf("t2_op%0d", i), 8, i == 4, cyc);
            chk($sformatf("t2_gap%0d", i), 32'(cyc), 4);
        end

        // Requester 2: drop Req and flip A during WAIT; original operands used.
        @(negedge clk);
        req = 4'b0100; a = 4'b0100; b = 4'b0100; c = 4'b0000;
        push(2);
        @(negedge clk);
        chk("t3_grant", 32'(grant), 4'b0100);
        req = '0; a[2] = 1'b0;
        @(negedge clk);
        chk("t3_dpa_held", 32'(dp_a), 1);
        wait_done("t3", 6, 1'b0, cyc);

        // Reset during WAIT abandons requester 1; requester 3 then served.
        @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        chk("t4_grant", 32'(grant), 4'b0010);
        @(negedge clk);
        #2 rst_n = 1'b0; req = '0;
        #1 all_zero("t4_async");
        @(negedge clk);
        chk("t4_rst_done", 32'(done), 0);
        @(negedge clk);
        chk("t4_rst_done2", 32'(done), 0);
        rst_n = 1'b1;
        req = 4'b1000; a = 4'b0000; b = 4'b1000; c = 4'b1000;
        push(3);
        wait_done("t4", 8, 1'b1, cyc);

        // Faulty X from the datapath: Err set when checking is built in.
        @(negedge clk);
        force_x0 = 1'b1;
        req = 4'b0001; a = 4'b0001; b = '0; c = '0;
        push(0);
        wait_done("t5", 8, 1'b1, cyc);
        force_x0 = 1'b0;
        @(negedge clk);
        chk("t5_err", 32'(err), 32'(exp_err));
        req = 4'b0001; a = 4'b0001; b = 4'b0001; c = 4'b0001;
        push(0);
        wait_done("t5_clean", 8, 1'b1, cyc);
        @(negedge clk);
        chk("t5_err_sticky", 32'(err), 32'(exp_err));

        // Idle for 20 cycles with wandering operands: nothing moves.
        for (int i = 0; i < 20; i++) begin
            a = 4'($urandom); b = 4'($urandom); c = 4'($urandom);
            @(negedge clk);
            chk($sformatf("t6_done%0d", i), 32'(done), 0);
            chk($sformatf("t6_grant%0d", i), 32'(grant), 0);
        end
        chk("t6_dp", 32'({dp_a, dp_b, dp_c}), 3'b111);
        chk("t6_sb_empty", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/xornor_arbiter.md
XORNOR_ARBITER -- requirements
Module: xornor_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one XorNor datapath; legal range 2..8.
REQ-002 Parameter SETTLE, default 2: clock cycles allowed for datapath settling; legal range 1..15.
REQ-003 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Req  input  NREQ  per-requester level request.
REQ-006 In_A, In_B, In_C  input  NREQ each  per-requester operand bits.
REQ-007 Dp_A, Dp_B, Dp_C  output  1 each  registered operands driven to the shared XorNor.
REQ-008 Dp_X, Dp_Y  input  1 each  XorNor results.
REQ-009 Grant  output  NREQ  one-hot, registered; identifies the requester being served.
REQ-010 Done  output  1  one-cycle result-valid pulse.
REQ-011 Res_X, Res_Y  output  1 each  captured results; hold value until next Done.
REQ-012 Res_Id  output  $clog2(NREQ)  index of the requester served; valid with Done, held after.
REQ-013 Err  output  1  sticky self-check flag (see Configuration).

Function
REQ-014 FSM states: IDLE, WAIT, CAP; encoded as a 2-bit enum.
REQ-015 IDLE, Req==0: remain IDLE; Dp_* and Res_* hold; Grant=0.
REQ-016 IDLE, Req!=0 (issue edge): pick the winner, load Dp_A/B/C from In_*[win], set Grant one-hot, set cnt=0, go to WAIT.
REQ-017 Winner: round-robin; search starts at last_served+1 mod NREQ and takes the first set Req bit.
REQ-018 WAIT: cnt increments each edge; on the edge with cnt==SETTLE-1, go to CAP; the FSM spends exactly SETTLE cycles in WAIT.
REQ-019 CAP edge: register Dp_X->Res_X, Dp_Y->Res_Y, win->Res_Id, last_served=win; Done=1 for one cycle; Grant=0; go to IDLE.
REQ-020 Latency: Done is high in the cycle following the (SETTLE+1)th edge after the issue edge; throughput is one operation per SETTLE+2 cycles.
REQ-021 Operands are sampled only at the issue edge; In_* changes during WAIT/CAP do not affect Dp_*.
REQ-022 Req deasserted mid-operation: the operation completes and Done fires normally.
REQ-023 Requester protocol: hold Req until Done with matching Res_Id; Req still high in the following IDLE cycle is a new request.
REQ-024 Single requester held continuously is re-served back to back; no requester waits more than NREQ-1 operations.

Reset
REQ-025 Rst_n low: immediately, regardless of Clk: state=IDLE, cnt=0, Dp_*=0, Grant=0, Done=0, Res_*=0, Res_Id=0, Err=0, last_served=NREQ-1 (requester 0 first).
REQ-026 Reset during WAIT/CAP abandons the operation; no Done is produced for it.

Configuration
REQ-027 Macro XORNOR_ARB_CHECK_EN defined: at the CAP edge compare Dp_X with Dp_A^Dp_B and Dp_Y with ~((Dp_A^Dp_B)|Dp_C); on mismatch set Err=1, cleared only by reset.
REQ-028 Macro undefined: no checker logic; Err is tied to 0; all other behaviour is identical.

Structure
REQ-029 Package xornor_pkg holds the state enum typedef, the NREQ/SETTLE default constants, and the Res_Id width function.
REQ-030 Sub-module xornor_rr_pick: combinational round-robin picker (Req, last_served -> win, any).
REQ-031 The XorNor datapath is external; the bench instantiates it on Dp_*.

Verification (NREQ=4, SETTLE=2, 10 ns Clk, XorNor attached)
REQ-032 Req=4'b0001, A0=1, B0=0, C0=0 -> Grant=4'b0001 for 3 cycles, then Done with Res_X=1, Res_Y=0, Res_Id=0, 3 edges after issue.
REQ-033 Req=4'b1111 held -> Res_Id sequence is 0,1,2,3,0 with Done spaced 4 cycles apart.
REQ-034 Issue requester 2, drop Req[2] and toggle In_A[2] during WAIT -> Done still fires with results from the originally sampled operands.
REQ-035 Rst_n low during WAIT -> all outputs 0 asynchronously, no Done; after release, Req=4'b1000 is served with Res_Id=3.
REQ-036 XORNOR_ARB_CHECK_EN defined, Dp_X forced 0 with A=1, B=0 -> Err=1 after CAP and stays set; macro undefined -> Err stays 0.
REQ-037 Req=0 for 20 cycles -> no Done, Grant=0, Dp_* unchanged.
